// File: rtl/acu_fetch_seq.sv
// Address fetch sequencer: pulls low/high address bytes from a valid/ready source,
// replays them to the 16-bit capture unit as wl/wh writes, then holds oe for a window.
module acu_fetch_seq #(
  parameter int unsigned OE_CYCLES = 1,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [7:0]  i_byte_data,
  input  logic        i_byte_valid,
  output logic        o_byte_ready,
  output logic [7:0]  o_d,
  output logic        o_wl,
  output logic        o_wh,
  output logic        o_oe,
  output logic [15:0] o_shadow_addr,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  localparam int unsigned WAIT_W = 16;
  localparam int unsigned OE_W   = 4;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FETCH_LO = 3'd1;
  localparam logic [2:0] S_WRITE_LO = 3'd2;
  localparam logic [2:0] S_FETCH_HI = 3'd3;
  localparam logic [2:0] S_WRITE_HI = 3'd4;
  localparam logic [2:0] S_DRIVE    = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;
  localparam logic [2:0] S_ERR      = 3'd7;

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [WAIT_W-1:0] r_wait;
  logic [OE_W-1:0]   r_oe_cnt;
  logic              w_fetch;
  logic              w_accept;
  logic              w_timeout;
  logic              w_oe_last;

  // o_byte_ready mirrors the current state, so it doubles as the fetch-state flag
  assign w_fetch   = (r_state == S_FETCH_LO) || (r_state == S_FETCH_HI);
  assign w_accept  = w_fetch && o_byte_ready && i_byte_valid;
  assign w_timeout = (r_wait == WAIT_W'(TIMEOUT));
  assign w_oe_last = (r_oe_cnt == OE_W'(OE_CYCLES - 1));

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (i_start) w_next = S_FETCH_LO;
      S_FETCH_LO: begin
        if (w_accept)       w_next = S_WRITE_LO;
        else if (w_timeout) w_next = S_ERR;
      end
      S_WRITE_LO: w_next = S_FETCH_HI;
      S_FETCH_HI: begin
        if (w_accept)       w_next = S_WRITE_HI;
        else if (w_timeout) w_next = S_ERR;
      end
      S_WRITE_HI: w_next = S_DRIVE;
      S_DRIVE:    if (w_oe_last) w_next = S_DONE;
      S_DONE:     w_next = S_IDLE;
      S_ERR:      w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // State, counters, data path and outputs registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_wait        <= '0;
      r_oe_cnt      <= '0;
      o_d           <= 8'h00;
      o_shadow_addr <= 16'h0000;
      o_byte_ready  <= 1'b0;
      o_wl          <= 1'b0;
      o_wh          <= 1'b0;
      o_oe          <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      r_state <= w_next;

      if (w_fetch && !w_accept && (w_next == r_state)) r_wait <= r_wait + WAIT_W'(1);
      else                                             r_wait <= '0;

      if ((r_state == S_DRIVE) && (w_next == S_DRIVE)) r_oe_cnt <= r_oe_cnt + OE_W'(1);
      else                                             r_oe_cnt <= '0;

      if (w_accept) begin
        o_d <= i_byte_data;
        if (r_state == S_FETCH_LO) o_shadow_addr[7:0]  <= i_byte_data;
        else                       o_shadow_addr[15:8] <= i_byte_data;
      end

      o_byte_ready <= (w_next == S_FETCH_LO) || (w_next == S_FETCH_HI);
      o_wl         <= (w_next == S_WRITE_LO);
      o_wh         <= (w_next == S_WRITE_HI);
      o_oe         <= (w_next == S_DRIVE);
      o_busy       <= (w_next != S_IDLE);
      o_done       <= (w_next == S_DONE);
      o_err        <= (w_next == S_ERR);
    end
  end

endmodule
